mem_bus_checker: RTL

Synthesisable self-check monitor for the native core memory interface (valid/ready/addr/wdata/wstrb). It sits beside the core in `top`, snooping the bus without driving it. It counts read and write handshakes and records the last N transactions in a trace ring. It reaches a pass/fail verdict from a tohost write, a bus-stall watchdog or a global timeout, and the same verdict logic is used in simulation and on FPGA.

---
 rtl/mem_bus_pkg.sv | 30 +++
 rtl/mem_trace_buf.sv | 75 +++++++
 rtl/mem_bus_checker.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types, defaults and helpers for the memory-bus self-check monitor.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } checker_state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_TOHOST  = 2'd1,
    FC_STALL   = 2'd2,
    FC_TIMEOUT = 2'd3
  } fail_code_e;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h1000_0000;

  // One trace record at the default 32-bit bus geometry.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstrb;
  } trace_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_trace_buf.sv
// Ring buffer of the most recent bus transactions; read side indexes newest-first
// and returns zero for slots that have never been written since reset.
module mem_trace_buf
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 68
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0]   FILL_FULL = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]   FILL_ONE  = (IDX_W + 1)'(1);
  localparam logic [IDX_W-1:0] PTR_ONE   = IDX_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   fill_q, fill_d;
  logic [IDX_W-1:0] rd_pos_s;

  // Push writes the slot at the pointer; the pointer wraps naturally (power-of-two depth).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_ONE;
      end else begin
        fill_d = fill_q;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Newest-first read, gated by the fill level.
  always_comb begin
    rd_pos_s = wr_ptr_q - PTR_ONE - rd_idx;
    if ({1'b0, rd_idx} < fill_q) begin
      rd_data = mem_q[rd_pos_s];
    end else begin
      rd_data = {WIDTH{1'b0}};
    end
  end

  // Entry storage carries no reset; stale contents are hidden by the fill gate.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and fill registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= {IDX_W{1'b0}};
      fill_q   <= {(IDX_W + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  assign fill = fill_q;

endmodule

// File: rtl/mem_bus_checker.sv
// Passive monitor for the native memory bus: handshake counters, trace ring and a
// sticky pass/fail verdict from tohost, stall watchdog or global timeout.
module mem_bus_checker
  import mem_bus_pkg::*;
#(
  parameter int unsigned        ADDR_W         = 32,
  parameter int unsigned        DATA_W         = 32,
  parameter int unsigned        TRACE_DEPTH    = 8,
  parameter logic [ADDR_W-1:0]  TOHOST_ADDR    = ADDR_W'(TOHOST_ADDR_DEFAULT),
  parameter int unsigned        STALL_LIMIT    = 64,
  parameter int unsigned        TIMEOUT_CYCLES = 500000
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           mem_valid,
  input  logic                           mem_ready,
  input  logic [ADDR_W-1:0]              mem_addr,
  input  logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W/8-1:0]            mem_wstrb,
  output logic                           done,
  output logic                           pass,
  output logic [1:0]                     fail_code,
  output logic [DATA_W-1:0]              result,
  output logic [31:0]                    rd_count,
  output logic [31:0]                    wr_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [ADDR_W-1:0]              trace_addr,
  output logic [DATA_W-1:0]              trace_data,
  output logic [DATA_W/8-1:0]            trace_wstrb,
  output logic [$clog2(TRACE_DEPTH):0]   trace_fill
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W + STRB_W;
  localparam logic [31:0]       STALL_LAST   = 32'(STALL_LIMIT - 1);
  localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] DATA_ONE     = DATA_W'(1);

  checker_state_e    state_q, state_d;
  fail_code_e        fail_code_q, fail_code_d, verdict_s;
  logic              done_q, done_d, pass_q, pass_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [31:0]       rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d, cycle_cnt_q, cycle_cnt_d;

  logic hs_s, is_wr_s, stall_s, running_s, tohost_s, stall_hit_s, timeout_hit_s;
  logic [DATA_W-1:0]  entry_data_s;
  logic [ENTRY_W-1:0] entry_s, trace_rd_s;

  assign hs_s          = mem_valid && mem_ready;
  assign is_wr_s       = |mem_wstrb;
  assign stall_s       = mem_valid && !mem_ready;
  assign running_s     = (state_q == ST_RUN);
  assign tohost_s      = hs_s && is_wr_s && (mem_addr == TOHOST_ADDR);
  assign stall_hit_s   = stall_s && (stall_cnt_q >= STALL_LAST);
  assign timeout_hit_s = (cycle_cnt_q >= TIMEOUT_LAST);

  // Next state; tohost outranks stall, which outranks timeout.
  always_comb begin
    state_d   = state_q;
    verdict_s = FC_NONE;
    case (state_q)
      ST_RUN: begin
        if (tohost_s) begin
          if (mem_wdata == DATA_ONE) begin
            state_d   = ST_PASS;
            verdict_s = FC_NONE;
          end else begin
            state_d   = ST_FAIL;
            verdict_s = FC_TOHOST;
          end
        end else if (stall_hit_s) begin
          state_d   = ST_FAIL;
          verdict_s = FC_STALL;
        end else if (timeout_hit_s) begin
          state_d   = ST_FAIL;
          verdict_s = FC_TIMEOUT;
        end else begin
          state_d   = ST_RUN;
          verdict_s = FC_NONE;
        end
      end
      ST_PASS: state_d = ST_PASS;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_FAIL;
    endcase
  end

  // Verdict outputs, latched alongside the state transition.
  always_comb begin
    done_d = (state_d != ST_RUN);
    pass_d = (state_d == ST_PASS);
    if (running_s) begin
      fail_code_d = verdict_s;
      if (tohost_s) begin
        result_d = {1'b0, mem_wdata[DATA_W-1:1]};
      end else begin
        result_d = result_q;
      end
    end else begin
      fail_code_d = fail_code_q;
      result_d    = result_q;
    end
  end

  // Handshake counters and watchdogs; everything freezes once a verdict is reached.
  always_comb begin
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    stall_cnt_d = stall_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    if (running_s) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (hs_s) begin
        stall_cnt_d = 32'd0;
        if (is_wr_s) begin
          wr_count_d = sat_inc32(wr_count_q);
        end else begin
          rd_count_d = sat_inc32(rd_count_q);
        end
      end else if (stall_s) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_d = 32'd0;
      end
    end else begin
      cycle_cnt_d = cycle_cnt_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= FC_NONE;
      result_q    <= {DATA_W{1'b0}};
      rd_count_q  <= 32'd0;
      wr_count_q  <= 32'd0;
      stall_cnt_q <= 32'd0;
      cycle_cnt_q <= 32'd0;
    end else begin
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_code_q <= fail_code_d;
      result_q    <= result_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      stall_cnt_q <= stall_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign entry_data_s = is_wr_s ? mem_wdata : {DATA_W{1'b0}};
  assign entry_s      = {mem_addr, entry_data_s, mem_wstrb};

  mem_trace_buf #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_trace (
    .clk       (clk),
    .resetn    (resetn),
    .push      (hs_s && running_s),
    .push_data (entry_s),
    .rd_idx    (trace_idx),
    .rd_data   (trace_rd_s),
    .fill      (trace_fill)
  );

  assign trace_addr  = trace_rd_s[ENTRY_W-1 -: ADDR_W];
  assign trace_data  = trace_rd_s[STRB_W +: DATA_W];
  assign trace_wstrb = trace_rd_s[STRB_W-1:0];

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = fail_code_q;
  assign result    = result_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule
